// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 16-bit pipelined CPU.
// Forwards ALU results to write-back and runs LOAD/STORE through a
// request/ready handshake with data memory, stalling upstream and
// bubbling downstream while an access is outstanding.
module mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        state,
    input  logic [15:0] mem_ir,
    input  logic [15:0] reg_C,
    input  logic [15:0] smdr,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    output logic [15:0] wb_ir,
    output logic [15:0] reg_C1,
    output logic        stall,
    output logic        mem_fault
);

    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 5;
    localparam int unsigned CW  = 4;

    // Opcodes shared with the rest of the pipeline.
    localparam logic [OPW-1:0] OP_LOAD  = 5'b00010;
    localparam logic [OPW-1:0] OP_STORE = 5'b00011;

    // CPU run state encoding for "executing".
    localparam logic EXEC = 1'b1;

    localparam logic [DW-1:0] NOP_IR   = 16'h0000;
    localparam logic [DW-1:0] LOAD_BAD = 16'hFFFF;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } fsm_t;

    fsm_t            fsm_q,   fsm_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            req_d,   we_d,    fault_d;
    logic [DW-1:0]   addr_d,  wdata_d, wb_ir_d, reg_c1_d;

    logic [OPW-1:0]  opcode;
    logic            is_load;
    logic            is_store;
    logic            is_mem;
    logic            at_limit;

    // Opcode decode of the instruction currently in this stage.
    always_comb begin
        opcode   = mem_ir[15:11];
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        is_mem   = is_load || is_store;
        at_limit = (cnt_q == CNT_LAST);
    end

    // Upstream hold: issuing cycle and every non-final wait cycle.
    always_comb begin
        stall = ((fsm_q == IDLE) && is_mem) ||
                ((fsm_q == ACCESS) && !dmem_ready && !at_limit);
    end

    // Next-state and next-output decode; everything holds by default.
    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        req_d    = dmem_req;
        we_d     = dmem_we;
        addr_d   = dmem_addr;
        wdata_d  = dmem_wdata;
        wb_ir_d  = wb_ir;
        reg_c1_d = reg_C1;
        fault_d  = mem_fault;

        unique case (fsm_q)
            IDLE: begin
                if (is_mem) begin
                    // Launch the access and send a bubble downstream.
                    req_d    = 1'b1;
                    we_d     = is_store;
                    addr_d   = reg_C;
                    wdata_d  = smdr;
                    wb_ir_d  = NOP_IR;
                    reg_c1_d = NOP_IR;
                    cnt_d    = '0;
                    fsm_d    = ACCESS;
                end else begin
                    wb_ir_d  = mem_ir;
                    reg_c1_d = reg_C;
                end
            end

            ACCESS: begin
                if (dmem_ready) begin
                    // Completion wins over a coincident timeout.
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    wb_ir_d  = mem_ir;
                    reg_c1_d = is_load ? dmem_rdata : reg_C;
                    fsm_d    = IDLE;
                end else if (at_limit) begin
                    // Give up on the access and flag it permanently.
                    req_d    = 1'b0;
                    fault_d  = 1'b1;
                    wb_ir_d  = mem_ir;
                    reg_c1_d = is_load ? LOAD_BAD : reg_C;
                    fsm_d    = IDLE;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    wb_ir_d  = NOP_IR;
                end
            end

            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State and output registers; frozen outside exec, reset overrides.
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q      <= IDLE;
            cnt_q      <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_ir      <= '0;
            reg_C1     <= '0;
            mem_fault  <= 1'b0;
        end else if (state == EXEC) begin
            fsm_q      <= fsm_d;
            cnt_q      <= cnt_d;
            dmem_req   <= req_d;
            dmem_we    <= we_d;
            dmem_addr  <= addr_d;
            dmem_wdata <= wdata_d;
            wb_ir      <= wb_ir_d;
            reg_C1     <= reg_c1_d;
            mem_fault  <= fault_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage with a queue-based scoreboard.
// The driver pushes the hand-computed expectation for each cycle; a separate
// monitor pops it and compares against what the DUT presents.
module tb_mem_stage;

    localparam logic [15:0] I_ADD = 16'h4123;  // opcode 01000
    localparam logic [15:0] I_SUB = 16'h4A55;  // opcode 01001
    localparam logic [15:0] I_LDA = 16'h1040;  // LOAD
    localparam logic [15:0] I_ST  = 16'h1810;  // STORE
    localparam logic [15:0] I_LDF = 16'h1048;  // LOAD, freeze case
    localparam logic [15:0] I_LDT = 16'h1044;  // LOAD, timeout case
    localparam logic [15:0] I_LDR = 16'h104C;  // LOAD, reset case

    logic        clock = 1'b0;
    logic        reset;
    logic        state;
    logic [15:0] mem_ir, reg_C, smdr, dmem_rdata;
    logic        dmem_ready;
    logic        dmem_req, dmem_we, stall, mem_fault;
    logic [15:0] dmem_addr, dmem_wdata, wb_ir, reg_C1;

    typedef struct {
        string       tag;
        logic        stall;
        logic [15:0] wb;
        logic [15:0] c1;
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        fault;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    mem_stage #(.TIMEOUT(15)) dut (
        .clock      (clock),
        .reset      (reset),
        .state      (state),
        .mem_ir     (mem_ir),
        .reg_C      (reg_C),
        .smdr       (smdr),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .wb_ir      (wb_ir),
        .reg_C1     (reg_C1),
        .stall      (stall),
        .mem_fault  (mem_fault)
    );

    task automatic chk(input string tag, input string f,
                       input logic [15:0] act, input logic [15:0] exp);
        if (!$isunknown(exp)) begin
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL %s.%s: got %h, want %h", tag, f, act, exp);
            end
        end
    endtask

    // One cycle: inputs applied at the falling edge, expectation queued.
    task automatic step(input string tag, input logic st, input logic rst,
                        input logic [15:0] ir, input logic [15:0] c,
                        input logic [15:0] sd, input logic [15:0] rd,
                        input logic rdy,
                        input logic e_stall, input logic [15:0] e_wb,
                        input logic [15:0] e_c1, input logic e_req,
                        input logic e_we, input logic [15:0] e_addr,
                        input logic [15:0] e_wdata, input logic e_fault);
        exp_t e;
        @(negedge clock);
        state      = st;
        reset      = rst;
        mem_ir     = ir;
        reg_C      = c;
        smdr       = sd;
        dmem_rdata = rd;
        dmem_ready = rdy;
        e.tag   = tag;
        e.stall = e_stall;
        e.wb    = e_wb;
        e.c1    = e_c1;
        e.req   = e_req;
        e.we    = e_we;
        e.addr  = e_addr;
        e.wdata = e_wdata;
        e.fault = e_fault;
        q.push_back(e);
    endtask

    // Monitor: stall just before the edge, registered outputs just after.
    initial begin
        forever begin
            logic s;
            exp_t e;
            @(negedge clock);
            #3 s = stall;
            @(posedge clock);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk(e.tag, "stall",      16'(s),         16'(e.stall));
                chk(e.tag, "wb_ir",      wb_ir,          e.wb);
                chk(e.tag, "reg_C1",     reg_C1,         e.c1);
                chk(e.tag, "dmem_req",   16'(dmem_req),  16'(e.req));
                chk(e.tag, "dmem_we",    16'(dmem_we),   16'(e.we));
                chk(e.tag, "dmem_addr",  dmem_addr,      e.addr);
                chk(e.tag, "dmem_wdata", dmem_wdata,     e.wdata);
                chk(e.tag, "mem_fault",  16'(mem_fault), 16'(e.fault));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; state = 1'b1; mem_ir = '0; reg_C = '0;
        smdr = '0; dmem_rdata = '0; dmem_ready = 1'b0;

        // tag            st rst ir     reg_C    smdr     rdata    rdy | stall wb     reg_C1   req we addr     wdata    fault
        step("rst0",      1, 1, 16'h0, 16'h0,    16'h0,   16'h0,   0,    1'bx, 16'h0, 16'h0,   0, 0, 16'h0,   16'h0,   0);
        step("rst1",      1, 1, 16'h0, 16'h0,    16'h0,   16'h0,   0,    0,    16'h0, 16'h0,   0, 0, 16'h0,   16'h0,   0);
        step("add",       1, 0, I_ADD, 16'h1234, 16'h0,   16'h0,   0,    0,    I_ADD, 16'h1234,0, 0, 16'h0,   16'h0,   0);
        step("sub",       1, 0, I_SUB, 16'h0007, 16'h0,   16'h0,   0,    0,    I_SUB, 16'h0007,0, 0, 16'h0,   16'h0,   0);
        step("idle_rdy",  1, 0, I_ADD, 16'h0099, 16'h0,   16'h9999,1,    0,    I_ADD, 16'h0099,0, 0, 16'h0,   16'h0,   0);

        // LOAD answered in the first ACCESS cycle
        step("ld_issue",  1, 0, I_LDA, 16'h0040, 16'h0,   16'h0,   0,    1,    16'h0, 16'h0,   1, 0, 16'h0040,16'h0,   0);
        step("ld_done",   1, 0, I_LDA, 16'h0040, 16'h0,   16'hBEEF,1,    0,    I_LDA, 16'hBEEF,0, 0, 16'h0040,16'h0,   0);
        step("add2",      1, 0, I_ADD, 16'h1111, 16'h0,   16'h0,   0,    0,    I_ADD, 16'h1111,0, 0, 16'h0040,16'h0,   0);

        // STORE with three wait cycles
        step("st_issue",  1, 0, I_ST,  16'h0010, 16'h5A5A,16'h0,   0,    1,    16'h0, 16'h0,   1, 1, 16'h0010,16'h5A5A,0);
        for (int i = 0; i < 3; i++)
            step("st_wait",1, 0, I_ST,  16'h0010, 16'h5A5A,16'h0,   0,    1,    16'h0, 16'h0,   1, 1, 16'h0010,16'h5A5A,0);
        step("st_done",   1, 0, I_ST,  16'h0010, 16'h5A5A,16'hDEAD,1,    0,    I_ST,  16'h0010,0, 0, 16'h0010,16'h5A5A,0);

        // LOAD frozen out of exec, then ready exactly at the timeout count
        step("fz_issue",  1, 0, I_LDF, 16'h0048, 16'h0,   16'h0,   0,    1,    16'h0, 16'h0,   1, 0, 16'h0048,16'h0,   0);
        step("fz_wait",   1, 0, I_LDF, 16'h0048, 16'h0,   16'h0,   0,    1,    16'h0, 16'h0,   1, 0, 16'h0048,16'h0,   0);
        for (int i = 0; i < 5; i++)
            step("fz_hold",0, 0, I_LDF, 16'h0048, 16'h0,   16'h0,   0,    1,    16'h0, 16'h0,   1, 0, 16'h0048,16'h0,   0);
        for (int i = 0; i < 13; i++)
            step("fz_wait2",1, 0, I_LDF, 16'h0048, 16'h0,  16'h0,   0,    1,    16'h0, 16'h0,   1, 0, 16'h0048,16'h0,   0);
        step("fz_done",   1, 0, I_LDF, 16'h0048, 16'h0,   16'hCAFE,1,    0,    I_LDF, 16'hCAFE,0, 0, 16'h0048,16'h0,   0);

        // LOAD never answered: abandoned after 15 ACCESS cycles
        step("to_issue",  1, 0, I_LDT, 16'h0044, 16'h0,   16'h0,   0,    1,    16'h0, 16'h0,   1, 0, 16'h0044,16'h0,   0);
        for (int i = 0; i < 14; i++)
            step("to_wait",1, 0, I_LDT, 16'h0044, 16'h0,   16'h0,   0,    1,    16'h0, 16'h0,   1, 0, 16'h0044,16'h0,   0);
        step("to_abort",  1, 0, I_LDT, 16'h0044, 16'h0,   16'h0,   0,    0,    I_LDT, 16'hFFFF,0, 0, 16'h0044,16'h0,   1);
        step("to_sticky", 1, 0, I_ADD, 16'h2222, 16'h0,   16'h0,   0,    0,    I_ADD, 16'h2222,0, 0, 16'h0044,16'h0,   1);

        // Reset in the middle of an access
        step("rs_issue",  1, 0, I_LDR, 16'h004C, 16'h0,   16'h0,   0,    1,    16'h0, 16'h0,   1, 0, 16'h004C,16'h0,   1);
        step("rs_wait",   1, 0, I_LDR, 16'h004C, 16'h0,   16'h0,   0,    1,    16'h0, 16'h0,   1, 0, 16'h004C,16'h0,   1);
        step("rs_reset",  1, 1, I_LDR, 16'h004C, 16'h0,   16'h0,   0,    1,    16'h0, 16'h0,   0, 0, 16'h0,   16'h0,   0);
        step("rs_add",    1, 0, I_ADD, 16'h3333, 16'h0,   16'h0,   0,    0,    I_ADD, 16'h3333,0, 0, 16'h0,   16'h0,   0);

        repeat (4) @(posedge clock);
        #2;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit pipelined CPU, directly upstream of the write-back stage. It forwards ALU results and instructions to write-back, and it runs LOAD/STORE through a request/ready handshake with data memory. While an access is pending it stalls the upstream pipeline and sends NOP bubbles downstream. It produces the `wb_ir` / `reg_C1` pair that write-back consumes.

## Interface
- `TIMEOUT`, default 15: maximum number of ACCESS cycles with `dmem_ready` low before the access is abandoned. Range 2–15; the counter is 4 bits.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high. Sampled on the `clock` edge and overrides everything else.
- `state` in 1: CPU run state. All registers update only when `state == exec`; otherwise every register holds.
- `mem_ir` in 16: instruction in this stage. `mem_ir[15:11]` is the opcode, using the shared opcode macros.
- `reg_C` in 16: ALU result; this is the memory address for LOAD/STORE.
- `smdr` in 16: store data.
- `dmem_rdata` in 16: read data from data memory. Valid when `dmem_ready` is high.
- `dmem_ready` in 1: data memory completes the current request.
- `dmem_req` out 1: registered; request pending.
- `dmem_we` out 1: registered; 1 = write (STORE), 0 = read (LOAD).
- `dmem_addr` out 16: registered address.
- `dmem_wdata` out 16: registered write data.
- `wb_ir` out 16: registered instruction handed to write-back.
- `reg_C1` out 16: registered result handed to write-back.
- `stall` out 1: combinational. While high, upstream holds `mem_ir`, `reg_C` and `smdr` stable.
- `mem_fault` out 1: registered, sticky; set when an access times out.

## Operation
- Reset values:
  - `wb_ir`, `reg_C1`, `dmem_addr`, `dmem_wdata` = 16'h0000.
  - `dmem_req`, `dmem_we`, `mem_fault` = 0.
  - FSM = IDLE, timeout counter = 0.
- Memory op = opcode is LOAD or STORE. Any other opcode is a pass-through.
- IDLE with pass-through (exec cycle):
  - `wb_ir` <= `mem_ir`, `reg_C1` <= `reg_C`.
  - Stay in IDLE.
- IDLE with memory op (exec cycle):
  - `dmem_req` <= 1, `dmem_addr` <= `reg_C`, `dmem_wdata` <= `smdr`, `dmem_we` <= (opcode == STORE).
  - `wb_ir` <= 16'h0000 (NOP bubble), `reg_C1` <= 16'h0000.
  - Counter <= 0; go to ACCESS.
- ACCESS, `dmem_ready` = 1 (exec cycle):
  - `dmem_req` <= 0, `dmem_we` <= 0.
  - `wb_ir` <= `mem_ir`.
  - `reg_C1` <= `dmem_rdata` for LOAD, `reg_C` for STORE.
  - Go to IDLE.
- ACCESS, `dmem_ready` = 0, counter < `TIMEOUT`-1:
  - Counter +1.
  - `wb_ir` <= 16'h0000 (bubble).
  - `dmem_*` outputs hold.
- ACCESS, `dmem_ready` = 0, counter == `TIMEOUT`-1:
  - Abandon: `dmem_req` <= 0, `mem_fault` <= 1.
  - `wb_ir` <= `mem_ir`.
  - `reg_C1` <= 16'hFFFF for LOAD, `reg_C` for STORE.
  - Go to IDLE.
- `dmem_ready` and the timeout in the same cycle: ready wins; `mem_fault` is not set.
- `dmem_ready` while in IDLE is ignored.
- `stall` = (FSM == IDLE && memory op) || (FSM == ACCESS && !`dmem_ready` && counter != `TIMEOUT`-1). It is low in the completing cycle, so upstream advances on the same edge.
- `state != exec`: FSM, counter and all outputs freeze. `stall` is still evaluated by the formula above.
- Reset mid-access: the pending request is dropped immediately (`dmem_req` = 0 after the edge). No bubble is replayed.
- `mem_fault` clears only on reset.

## Timing
- Pass-through latency: 1 cycle, `mem_ir` to `wb_ir`. One instruction per cycle.
- Memory op with `dmem_ready` in the first ACCESS cycle:
  - Instruction seen in cycle N; `dmem_req` is high in cycle N+1.
  - Result is in `wb_ir` / `reg_C1` after the N+1 edge.
  - Upstream is stalled for exactly 1 cycle; write-back receives exactly 1 bubble.
- Each extra wait cycle adds 1 stall cycle and 1 bubble.
- Worst case: `TIMEOUT`+1 cycles from issue to completion.
- `dmem_addr`, `dmem_we` and `dmem_wdata` stay stable for the whole time `dmem_req` is high.
- Memory must sample `dmem_rdata` / `dmem_ready` in the same cycle `dmem_ready` is asserted.

## Test plan
- Reset then ADD in `mem_ir` with `reg_C`=16'h1234 -> next edge: `wb_ir`=ADD instruction, `reg_C1`=16'h1234, `stall`=0, `dmem_req`=0.
- LOAD with `reg_C`=16'h0040, `dmem_ready` high in the first ACCESS cycle with `dmem_rdata`=16'hBEEF:
  - `dmem_req`=1 and `dmem_addr`=16'h0040 for 1 cycle.
  - `wb_ir` is NOP for 1 cycle, then LOAD with `reg_C1`=16'hBEEF.
  - `stall` is high for 1 cycle.
- STORE with `reg_C`=16'h0010, `smdr`=16'h5A5A, `dmem_ready` after 3 wait cycles:
  - `dmem_we`=1, `dmem_wdata`=16'h5A5A held for 4 cycles.
  - 4 bubbles downstream, then STORE with `reg_C1`=16'h0010.
- LOAD with `dmem_ready` never asserted, `TIMEOUT`=15 -> after 15 ACCESS cycles: `mem_fault`=1, `reg_C1`=16'hFFFF, `dmem_req`=0. `mem_fault` stays 1 through later instructions.
- LOAD pending and `state` dropped out of exec for 5 cycles -> all outputs and the counter frozen. Completion proceeds normally on return to exec.
- Synchronous reset asserted during ACCESS -> after the edge: `dmem_req`=0, `wb_ir`=16'h0000, `stall`=0. The next instruction passes through normally.
